channel_switch_ctrl: RTL and testbench
======================================

CHANNEL_SWITCH_CTRL -- requirements
Module: channel_switch_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of probability input, Q4.12 signed.
REQ-002 Parameter THRESH_HI, default 16'h0B33: jam threshold, 0.70 in Q4.12.
REQ-003 Parameter THRESH_LO, default 16'h0666: clear threshold, 0.40 in Q4.12; THRESH_LO < THRESH_HI.
REQ-004 Parameter CONFIRM_CNT, default 3: consecutive qualifying samples needed to request a switch, range 1..15.
REQ-005 Parameter NUM_CHANNELS, default 8: channel count, range 2..256.
REQ-006 Parameter HOLDOFF_CYCLES, default 1024: post-switch blanking period in clocks, minimum 1.
REQ-007 Parameter ACK_TIMEOUT, default 256: maximum clocks to wait for switch_ack, minimum 1.
REQ-008 clk  input  1: single clock; all state updates on its rising edge.
REQ-009 rst_n  input  1: asynchronous, active-low reset.
REQ-010 prob_in  input  DATA_WIDTH: P(jammed) from the FC stage, Q4.12 signed.
REQ-011 prob_valid  input  1: one-cycle qualifier for prob_in.
REQ-012 switch_ack  input  1: radio acknowledges the channel change.
REQ-013 switch_req  output  1: level request to the radio, held until ack or timeout.
REQ-014 next_channel  output  $clog2(NUM_CHANNELS): target channel, stable while switch_req=1.
REQ-015 cur_channel  output  $clog2(NUM_CHANNELS): channel currently in use.
REQ-016 jammed_flag  output  1: hysteretic jam indicator.
REQ-017 timeout_err  output  1: one-cycle pulse on ack timeout.
REQ-018 switch_count  output  16: number of completed switches, saturating at 16'hFFFF.

Function
REQ-019 Comparisons against THRESH_HI and THRESH_LO are signed; negative prob_in counts as below THRESH_LO.
REQ-020 In every state, on prob_valid: jammed_flag sets if prob_in >= THRESH_HI, clears if prob_in < THRESH_LO, and otherwise holds.
REQ-021 The FSM has four states: S_MONITOR, S_REQ, S_HOLDOFF, and S_RECOVER (one-cycle return to S_MONITOR that clears hit_cnt).
REQ-022 In S_MONITOR, on prob_valid: hit_cnt increments if prob_in >= THRESH_HI, clears if prob_in < THRESH_LO, and holds if prob_in is between the thresholds.
REQ-023 When the CONFIRM_CNT-th qualifying sample arrives at cycle t, the block enters S_REQ with switch_req=1 and next_channel=(cur_channel+1) mod NUM_CHANNELS at t+1.
REQ-024 next_channel wraps: when cur_channel=NUM_CHANNELS-1, next_channel=0.
REQ-025 In S_REQ, switch_ack is sampled only while switch_req=1; an ack on cycle a sets cur_channel<=next_channel, increments switch_count (saturating), deasserts switch_req at a+1, and enters S_HOLDOFF.
REQ-026 An ack arriving in any state other than S_REQ is ignored.
REQ-027 If no ack arrives within ACK_TIMEOUT cycles of entering S_REQ, the block deasserts switch_req, pulses timeout_err, leaves cur_channel unchanged, and enters S_RECOVER.
REQ-028 In S_REQ, if ack and timeout coincide on the same cycle, the ack wins.
REQ-029 S_HOLDOFF lasts exactly HOLDOFF_CYCLES clocks; prob_valid does not affect hit_cnt during it; on expiry the block goes to S_RECOVER.
REQ-030 S_RECOVER clears hit_cnt and moves to S_MONITOR on the next cycle; samples arriving in S_RECOVER are ignored except for jammed_flag.
REQ-031 prob_valid has no backpressure; every sample is consumed in the cycle it is presented.

Reset
REQ-032 While rst_n=0, and immediately on its assertion: state=S_MONITOR, hit_cnt=0, switch_req=0, next_channel=0, cur_channel=0, jammed_flag=0, timeout_err=0, switch_count=0, and all timers=0.
REQ-033 A reset asserted mid-S_REQ or mid-S_HOLDOFF drops switch_req asynchronously and abandons the pending switch.

Structure
REQ-034 A shared package holds the Q4.12 constants (FRAC_BITS=12, ONE=16'h1000), the default thresholds, and the state encoding.
REQ-035 One sub-module, cycle_timer (loadable down-counter with expiry flag), is instantiated and shared between the ack timeout and the holdoff.

Verification
REQ-036 Three valid samples 16'h0C00 with idle gaps between them -> switch_req=1 one cycle after the third sample, next_channel=1, jammed_flag=1.
REQ-037 Samples 0C00, 0C00, 0800, 0C00 -> switch_req=1 after the fourth sample (the mid-band sample holds hit_cnt); samples 0C00, 0C00, 0400, 0C00 -> no request.
REQ-038 cur_channel=7 with a request and ack -> next_channel=0, cur_channel=0 after the ack, switch_count increments, and no request for 1024 cycles even with continuous 0F00 input.
REQ-039 Request with no ack for 256 cycles -> timeout_err is a one-cycle pulse, switch_req=0, cur_channel is unchanged, and hit_cnt restarts from 0.
REQ-040 rst_n pulsed low while switch_req=1 -> switch_req=0 asynchronously and all outputs take their reset values; a stray switch_ack in S_MONITOR causes no change.
REQ-041 Ack and timeout on the same cycle -> the switch completes and timeout_err stays 0.

Source files
------------

// File: rtl/channel_switch_ctrl_pkg.sv
// Shared constants for the channel switch controller: Q4.12 scaling,
// default jam/clear thresholds and the FSM state encoding.
package channel_switch_ctrl_pkg;

  localparam int          FRAC_BITS     = 12;
  localparam logic [15:0] ONE           = 16'h1000;
  localparam logic [15:0] THRESH_HI_DEF = 16'h0B33;  // 0.70
  localparam logic [15:0] THRESH_LO_DEF = 16'h0666;  // 0.40

  typedef enum logic [1:0] {
    S_MONITOR = 2'd0,
    S_REQ     = 2'd1,
    S_HOLDOFF = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/channel_switch_ctrl_cycle_timer.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - WIDTH'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/channel_switch_ctrl.sv
// Channel switch controller: hysteretic jam detection, confirmed switch
// request to the radio with ack timeout and post-switch holdoff.
//
// state     | meaning
// S_MONITOR | counting consecutive jam samples toward a switch request
// S_REQ     | switch_req held, waiting for switch_ack or ack timeout
// S_HOLDOFF | blanking after a completed switch, samples do not count
// S_RECOVER | single cycle that clears hit_cnt before monitoring again
module channel_switch_ctrl
  import channel_switch_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter logic [DATA_WIDTH-1:0] THRESH_HI      = THRESH_HI_DEF,
  parameter logic [DATA_WIDTH-1:0] THRESH_LO      = THRESH_LO_DEF,
  parameter int                    CONFIRM_CNT    = 3,
  parameter int                    NUM_CHANNELS   = 8,
  parameter int                    HOLDOFF_CYCLES = 1024,
  parameter int                    ACK_TIMEOUT    = 256,
  localparam int                   CW             = $clog2(NUM_CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] prob_in,
  input  logic                  prob_valid,
  input  logic                  switch_ack,
  output logic                  switch_req,
  output logic [CW-1:0]         next_channel,
  output logic [CW-1:0]         cur_channel,
  output logic                  jammed_flag,
  output logic                  timeout_err,
  output logic [15:0]           switch_count
);

  localparam int          TMR_MAX   = (HOLDOFF_CYCLES > ACK_TIMEOUT) ? HOLDOFF_CYCLES : ACK_TIMEOUT;
  localparam int          TW        = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLDOFF_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LOAD  = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]  HIT_LAST  = 4'(CONFIRM_CNT - 1);

  state_t          state, state_nxt;
  logic [3:0]      hit_cnt, hit_nxt;
  logic            tmr_load, tmr_expired;
  logic [TW-1:0]   tmr_val;
  logic            take_ack, ack_miss, enter_req;
  logic            is_hi, is_lo;
  logic [CW-1:0]   ch_inc;

  assign is_hi  = $signed(prob_in) >= $signed(THRESH_HI);
  assign is_lo  = $signed(prob_in) <  $signed(THRESH_LO);
  assign ch_inc = (cur_channel == CW'(NUM_CHANNELS - 1)) ? '0 : cur_channel + CW'(1);

  // Request is a pure state decode so an async reset drops it immediately.
  assign switch_req = (state == S_REQ);

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nxt = state;
    hit_nxt   = hit_cnt;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    take_ack  = 1'b0;
    ack_miss  = 1'b0;
    enter_req = 1'b0;
    case (state)
      S_MONITOR: begin
        if (prob_valid) begin
          if (is_hi) begin
            hit_nxt = hit_cnt + 4'd1;
            if (hit_cnt == HIT_LAST) begin
              state_nxt = S_REQ;
              enter_req = 1'b1;
              tmr_load  = 1'b1;
              tmr_val   = ACK_LOAD;
            end
          end else if (is_lo) begin
            hit_nxt = '0;
          end
        end
      end
      S_REQ: begin
        // ack beats a timeout landing on the same cycle
        if (switch_ack) begin
          take_ack  = 1'b1;
          state_nxt = S_HOLDOFF;
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LOAD;
        end else if (tmr_expired) begin
          ack_miss  = 1'b1;
          state_nxt = S_RECOVER;
        end
      end
      S_HOLDOFF: begin
        if (tmr_expired) state_nxt = S_RECOVER;
      end
      S_RECOVER: begin
        hit_nxt   = '0;
        state_nxt = S_MONITOR;
      end
      default: state_nxt = S_MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_MONITOR;
      hit_cnt      <= '0;
      next_channel <= '0;
      cur_channel  <= '0;
      jammed_flag  <= 1'b0;
      timeout_err  <= 1'b0;
      switch_count <= '0;
    end else begin
      state       <= state_nxt;
      hit_cnt     <= hit_nxt;
      timeout_err <= ack_miss;
      if (enter_req) next_channel <= ch_inc;
      if (take_ack) begin
        cur_channel <= next_channel;
        if (switch_count != 16'hFFFF) switch_count <= switch_count + 16'd1;
      end
      if (prob_valid) begin
        if (is_hi)      jammed_flag <= 1'b1;
        else if (is_lo) jammed_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_channel_switch_ctrl.sv
// Directed bench for channel_switch_ctrl; expected target channels are queued
// when a confirming sample is driven and compared when switch_req appears.
module tb_channel_switch_ctrl;

  localparam int HOLD = 1024;
  localparam int ACK  = 256;
  localparam int NCH  = 8;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   prob_in = '0;
  logic          prob_valid = 1'b0;
  logic          switch_ack = 1'b0;
  logic          switch_req;
  logic [CW-1:0] next_channel, cur_channel;
  logic          jammed_flag, timeout_err;
  logic [15:0]   switch_count;

  int            n_pass = 0;
  int            n_total = 0;
  int            k;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] m_cur = '0;
  logic [CW-1:0] m_next = '0;
  logic [15:0]   m_cnt = '0;

  always #5 clk = ~clk;

  channel_switch_ctrl #(
    .DATA_WIDTH(16), .THRESH_HI(16'h0B33), .THRESH_LO(16'h0666), .CONFIRM_CNT(3),
    .NUM_CHANNELS(NCH), .HOLDOFF_CYCLES(HOLD), .ACK_TIMEOUT(ACK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prob_in(prob_in), .prob_valid(prob_valid),
    .switch_ack(switch_ack), .switch_req(switch_req), .next_channel(next_channel),
    .cur_channel(cur_channel), .jammed_flag(jammed_flag), .timeout_err(timeout_err),
    .switch_count(switch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input logic [15:0] v);
    prob_in = v;
    prob_valid = 1'b1;
    tick();
    prob_valid = 1'b0;
  endtask

  task automatic push_exp();
    exp_q.push_back(CW'((int'(m_cur) + 1) % NCH));
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_req"}, switch_req, 1);
    check({tag, "_sb"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      m_next = exp_q.pop_front();
      check({tag, "_next"}, next_channel, m_next);
    end
  endtask

  task automatic ack_check(input string tag);
    switch_ack = 1'b1;
    tick();
    switch_ack = 1'b0;
    m_cur = m_next;
    m_cnt = m_cnt + 16'd1;
    check({tag, "_cur"}, cur_channel, m_cur);
    check({tag, "_cnt"}, switch_count, m_cnt);
    check({tag, "_req_drop"}, switch_req, 0);
    check({tag, "_tmo"}, timeout_err, 0);
  endtask

  task automatic do_switch(input string tag);
    sample(16'h0C00);
    sample(16'h0C00);
    push_exp();
    sample(16'h0C00);
    pop_check(tag);
    ack_check(tag);
    tick(HOLD + 1);
  endtask

  initial begin
    // reset values
    #2;
    check("rst_req", switch_req, 0);
    check("rst_next", next_channel, 0);
    check("rst_cur", cur_channel, 0);
    check("rst_jam", jammed_flag, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_cnt", switch_count, 0);
    tick(2);
    rst_n = 1'b1;
    tick();

    // three jam samples with idle gaps
    sample(16'h0C00);
    check("gap_jam", jammed_flag, 1);
    check("gap_req1", switch_req, 0);
    tick(2);
    sample(16'h0C00);
    check("gap_req2", switch_req, 0);
    tick(2);
    push_exp();
    sample(16'h0C00);
    pop_check("gap");
    ack_check("gap_ack");
    tick(HOLD + 1);

    // hysteresis boundaries, signed compare
    sample(16'h0800); check("jam_mid_hold", jammed_flag, 1);
    sample(16'h0400); check("jam_clear", jammed_flag, 0);
    sample(16'h0B33); check("jam_at_hi", jammed_flag, 1);
    sample(16'h0666); check("jam_at_lo", jammed_flag, 1);
    sample(16'hF000); check("jam_negative", jammed_flag, 0);
    sample(16'h0665); check("jam_below_lo", jammed_flag, 0);

    // mid-band sample holds hit_cnt
    sample(16'h0C00); sample(16'h0C00); sample(16'h0800);
    check("mid_noreq", switch_req, 0);
    push_exp();
    sample(16'h0C00);
    pop_check("mid");
    ack_check("mid_ack");
    tick(HOLD + 1);

    // low sample clears hit_cnt
    sample(16'h0C00); sample(16'h0C00); sample(16'h0400); sample(16'h0C00);
    check("low_noreq4", switch_req, 0);
    sample(16'h0C00);
    check("low_noreq5", switch_req, 0);
    push_exp();
    sample(16'h0C00);
    pop_check("low");
    ack_check("low_ack");
    tick(HOLD + 1);

    // ack timeout
    sample(16'h0C00); sample(16'h0C00);
    push_exp();
    sample(16'h0C00);
    pop_check("tmo");
    k = 0;
    while (!timeout_err && k < ACK + 20) begin
      tick();
      k++;
    end
    check("tmo_latency", k, ACK);
    check("tmo_req", switch_req, 0);
    check("tmo_cur", cur_channel, m_cur);
    check("tmo_cnt", switch_count, m_cnt);
    tick();
    check("tmo_pulse", timeout_err, 0);
    sample(16'h0C00); sample(16'h0C00);
    check("tmo_hit_restart", switch_req, 0);
    push_exp();
    sample(16'h0C00);
    pop_check("retry");

    // ack on the timeout cycle wins
    tick(ACK - 1);
    ack_check("coinc");
    tick();
    check("coinc_tmo_late", timeout_err, 0);
    tick(HOLD);

    // stray ack in monitor
    switch_ack = 1'b1;
    tick();
    switch_ack = 1'b0;
    check("stray_req", switch_req, 0);
    check("stray_cur", cur_channel, m_cur);
    check("stray_cnt", switch_count, m_cnt);

    for (int i = 0; i < NCH && m_cur != CW'(NCH - 1); i++) do_switch("walk");
    check("walk_cur7", cur_channel, NCH - 1);

    // wrap from last channel
    push_exp();
    sample(16'h0C00); sample(16'h0C00); sample(16'h0C00);
    pop_check("wrap");
    ack_check("wrap_ack");

    // holdoff length under continuous jam input
    push_exp();
    prob_in = 16'h0F00;
    prob_valid = 1'b1;
    k = 0;
    while (!switch_req && k < HOLD + 20) begin
      tick();
      k++;
    end
    prob_valid = 1'b0;
    check("hold_len", k, HOLD + 4);
    pop_check("hold");

    // async reset during a request
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", switch_req, 0);
    check("arst_next", next_channel, 0);
    check("arst_cur", cur_channel, 0);
    check("arst_jam", jammed_flag, 0);
    check("arst_cnt", switch_count, 0);
    exp_q.delete();
    m_cur = '0;
    m_cnt = '0;
    tick(2);
    rst_n = 1'b1;
    tick();
    check("arst_stay", switch_req, 0);
    do_switch("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
